// File: rtl/mem_port_arbiter.sv
// Arbitrates the instruction-fetch and data ports onto one fixed-latency memory.
// Data has priority, and a starvation counter forces fetch through after STARVE_MAX data wins.
module mem_port_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [2:0]        dm_funct3,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_funct3,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  typedef enum logic [1:0] {IDLE, WAIT_IF, WAIT_DM} state_e;

  localparam logic [3:0] LAT_M1     = 4'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_e            state_q, state_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic              store_q, store_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              dm_rvalid_q, dm_rvalid_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

  logic idle;
  logic force_if;
  logic grant_dm;
  logic grant_if;

  // Grants are gated by reset so every output reads 0 while reset is held.
  assign idle     = reset && (state_q == IDLE);
  assign force_if = if_req && (starve_cnt_q == STARVE_LIM);
  assign grant_dm = idle && dm_req && !force_if;
  assign grant_if = idle && if_req && !grant_dm;

  assign if_gnt    = grant_if;
  assign dm_gnt    = grant_dm;
  assign if_rvalid = if_rvalid_q;
  assign dm_rvalid = dm_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign stall     = reset && ((state_q != IDLE) || (if_req && !grant_if) || (dm_req && !grant_dm));

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_funct3 = '0;
    if (grant_dm) begin
      mem_en     = 1'b1;
      mem_we     = dm_we;
      mem_addr   = dm_addr;
      mem_wdata  = dm_wdata;
      mem_funct3 = dm_funct3;
    end else if (grant_if) begin
      mem_en     = 1'b1;
      mem_addr   = if_addr;
      mem_funct3 = 3'b010;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    starve_cnt_d = starve_cnt_q;
    store_d      = store_q;
    if_rvalid_d  = 1'b0;
    dm_rvalid_d  = 1'b0;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_dm) begin
          state_d    = WAIT_DM;
          wait_cnt_d = LAT_M1;
          store_d    = dm_we;
          if (if_req && (starve_cnt_q < STARVE_LIM)) starve_cnt_d = starve_cnt_q + 4'd1;
        end else if (grant_if) begin
          state_d      = WAIT_IF;
          wait_cnt_d   = LAT_M1;
          starve_cnt_d = '0;
        end
      end
      WAIT_IF, WAIT_DM: begin
        if (wait_cnt_q == 4'd0) begin
          state_d = IDLE;
          if (state_q == WAIT_IF) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata[31:0];
          end else begin
            dm_rvalid_d = 1'b1;
            // A store completes without disturbing the last load result.
            if (!store_q) dm_rdata_d = mem_rdata;
          end
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      wait_cnt_q   <= '0;
      starve_cnt_q <= '0;
      store_q      <= 1'b0;
      if_rvalid_q  <= 1'b0;
      dm_rvalid_q  <= 1'b0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      store_q      <= store_d;
      if_rvalid_q  <= if_rvalid_d;
      dm_rvalid_q  <= dm_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
    end
  end

endmodule
